// File: rtl/bitstream_loader.sv
// bitstream_loader: streams host bytes (LSB first) into a configuration chain
// through a divided programming clock (prog_clk / prog_en / prog_in).
// Optional feature: define BITSTREAM_LOADER_CRC_EN to enable readback CRC-8
// checking of prog_out against one trailing host byte.
module bitstream_loader #(
    parameter int CHAIN_LEN = 40,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       prog_in,
    input  logic       prog_out
);

    localparam logic [15:0] LAST_BIT = 16'(CHAIN_LEN);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        CHECK,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;   // chain bits already clocked in
    logic [7:0]  div_cnt_q, div_cnt_d;   // clk cycles spent in current half-period
    logic [2:0]  bit_idx_q, bit_idx_d;   // bit position within the current byte
    logic [7:0]  shift_q, shift_d;       // current byte, LSB is the next bit out
    logic [15:0] bit_cnt_inc;

    logic byte_ready_q, byte_ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic prog_clk_q, prog_clk_d;
    logic prog_en_q, prog_en_d;
    logic prog_in_q, prog_in_d;

`ifdef BITSTREAM_LOADER_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_err_q, crc_err_d;

    // CRC-8, poly 0x07, MSB-first register, one input bit per step
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`else
    // Without readback checking the chain output has no consumer
    logic unused_prog_out;
    assign unused_prog_out = prog_out;
`endif

    assign bit_cnt_inc = bit_cnt_q + 16'd1;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        prog_in_d = prog_in_q;
`ifdef BITSTREAM_LOADER_CRC_EN
        crc_d     = crc_q;
        crc_err_d = crc_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    bit_cnt_d = 16'd0;
`ifdef BITSTREAM_LOADER_CRC_EN
                    crc_d     = 8'h00;
                    crc_err_d = 1'b0;
`endif
                end
            end

            FETCH: begin
                // byte_ready_q is high exactly while in FETCH/CHECK
                if (byte_valid && byte_ready_q) begin
                    shift_d   = byte_data;
                    bit_idx_d = 3'd0;
                    div_cnt_d = 8'd0;
                    state_d   = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 8'd0;
                    state_d   = SHIFT_HI;
`ifdef BITSTREAM_LOADER_CRC_EN
                    // prog_clk rises on this edge; capture the chain output now
                    crc_d     = crc8_step(crc_q, prog_out);
`endif
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            SHIFT_HI: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 8'd0;
                    bit_cnt_d = bit_cnt_inc;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_cnt_inc == LAST_BIT) begin
`ifdef BITSTREAM_LOADER_CRC_EN
                        state_d = CHECK;
`else
                        state_d = FINISH;
`endif
                    end else if (bit_idx_q == 3'd7) begin
                        state_d = FETCH;
                    end else begin
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            CHECK: begin
`ifdef BITSTREAM_LOADER_CRC_EN
                if (byte_valid && byte_ready_q) begin
                    if (byte_data != crc_q) begin
                        crc_err_d = 1'b1;
                    end
                    state_d = FINISH;
                end
`else
                state_d = FINISH;
`endif
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register in step with it
        busy_d       = (state_d != IDLE) && (state_d != FINISH);
        done_d       = (state_d == FINISH);
        byte_ready_d = (state_d == FETCH) || (state_d == CHECK);
        prog_en_d    = busy_d;
        prog_clk_d   = (state_d == SHIFT_HI);
        // prog_in only moves on entry to / while in the low half-period
        if (state_d == SHIFT_LO) begin
            prog_in_d = shift_d[0];
        end
    end

    // State, counters and registered outputs; reset clears control only
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 16'd0;
            div_cnt_q    <= 8'd0;
            bit_idx_q    <= 3'd0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            prog_clk_q   <= 1'b0;
            prog_en_q    <= 1'b0;
            prog_in_q    <= 1'b0;
`ifdef BITSTREAM_LOADER_CRC_EN
            crc_q        <= 8'h00;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            prog_clk_q   <= prog_clk_d;
            prog_en_q    <= prog_en_d;
            prog_in_q    <= prog_in_d;
`ifdef BITSTREAM_LOADER_CRC_EN
            crc_q        <= crc_d;
            crc_err_q    <= crc_err_d;
`endif
        end
        shift_q <= shift_d;
    end

    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign prog_clk   = prog_clk_q;
    assign prog_en    = prog_en_q;
    assign prog_in    = prog_in_q;
`ifdef BITSTREAM_LOADER_CRC_EN
    assign crc_err    = crc_err_q;
`else
    assign crc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader: directed bench for bitstream_loader with chain models.
`timescale 1ns/1ps
module tb_bitstream_loader;

`ifdef BITSTREAM_LOADER_CRC_EN
    localparam int NI    = 3;
    localparam int EXTRA = 1;
`else
    localparam int NI    = 2;
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start [NI];
    logic       bv    [NI];
    logic [7:0] bd    [NI];
    logic       br    [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic       cerr  [NI];
    logic       pclk  [NI];
    logic       pen   [NI];
    logic       pin   [NI];
    logic       pout  [NI];

    int checks = 0;
    int errors = 0;

    int          edges, consumed, dones, viol, stall_seen, stall_bad;
    int          post_edges, post_dones;
    logic [63:0] rec;
    logic [7:0]  crc_m;
    logic        busy_at_done;
    logic        timeout;

    always #5 clk = ~clk;

    // Instance 0: 16-bit chain, fastest programming clock
    bitstream_loader #(.CHAIN_LEN(16), .CLK_DIV(1)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .byte_data(bd[0]), .byte_valid(bv[0]),
        .byte_ready(br[0]), .busy(busy[0]), .done(done[0]), .crc_err(cerr[0]),
        .prog_clk(pclk[0]), .prog_en(pen[0]), .prog_in(pin[0]), .prog_out(pout[0]));
    logic [15:0] chain_a = '0;
    always @(posedge pclk[0]) chain_a <= {chain_a[14:0], pin[0]};
    assign pout[0] = chain_a[15];

    // Instance 1: 10-bit chain, divided programming clock
    bitstream_loader #(.CHAIN_LEN(10), .CLK_DIV(2)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .byte_data(bd[1]), .byte_valid(bv[1]),
        .byte_ready(br[1]), .busy(busy[1]), .done(done[1]), .crc_err(cerr[1]),
        .prog_clk(pclk[1]), .prog_en(pen[1]), .prog_in(pin[1]), .prog_out(pout[1]));
    logic [9:0] chain_b = '0;
    always @(posedge pclk[1]) chain_b <= {chain_b[8:0], pin[1]};
    assign pout[1] = chain_b[9];

`ifdef BITSTREAM_LOADER_CRC_EN
    // Instance 2: 8-bit chain for readback CRC
    bitstream_loader #(.CHAIN_LEN(8), .CLK_DIV(1)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .byte_data(bd[2]), .byte_valid(bv[2]),
        .byte_ready(br[2]), .busy(busy[2]), .done(done[2]), .crc_err(cerr[2]),
        .prog_clk(pclk[2]), .prog_en(pen[2]), .prog_in(pin[2]), .prog_out(pout[2]));
    logic [7:0] chain_c = '0;
    always @(posedge pclk[2]) chain_c <= {chain_c[6:0], pin[2]};
    assign pout[2] = chain_c[7];
`endif

    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic d);
        logic fb;
        fb = c[7] ^ d;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One load on instance idx; records every prog_clk rising edge.
    task automatic run_load(input int idx, input int nb, input logic [7:0] b0, input logic [7:0] b1,
                            input int stall_byte, input int stall_cyc, input logic flip,
                            input int abort_edge, input int restart_cyc);
        int   bi, stall_left;
        logic pc_prev, pi_prev, po_prev, hs, fin;
        edges = 0; consumed = 0; dones = 0; viol = 0; stall_seen = 0; stall_bad = 0;
        rec = '0; crc_m = 8'h00; busy_at_done = 1'b1; timeout = 1'b0;
        bi = 0; stall_left = stall_cyc; fin = 1'b0;
        start[idx] = 1'b1;
        @(posedge clk); #1;
        start[idx] = 1'b0;
        pc_prev = pclk[idx]; pi_prev = pin[idx]; po_prev = pout[idx];
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            start[idx] = (cyc == restart_cyc);
            if (bi < nb) begin
                if (bi == stall_byte && stall_left > 0) begin
                    bv[idx] = 1'b0;
                    if (br[idx]) begin
                        stall_left--;
                        stall_seen++;
                        if (pclk[idx] !== 1'b0 || pen[idx] !== 1'b1) stall_bad++;
                    end
                end else begin
                    bv[idx] = 1'b1;
                    bd[idx] = (bi == 0) ? b0 : b1;
                end
            end else if (bi == nb && EXTRA == 1) begin
                bv[idx] = 1'b1;
                bd[idx] = crc_m ^ {7'd0, flip};
            end else begin
                bv[idx] = 1'b0;
            end
            hs = bv[idx] && br[idx];
            @(posedge clk); #1;
            if (hs) begin
                bi++;
                consumed++;
            end
            if (pclk[idx] && !pc_prev) begin
                if (edges < 64) rec[edges] = pin[idx];
                crc_m = crc_ref(crc_m, po_prev);
                edges++;
            end
            if (pclk[idx] && (pin[idx] !== pi_prev)) viol++;
            if (done[idx]) begin
                dones++;
                busy_at_done = busy[idx];
                fin = 1'b1;
            end
            pc_prev = pclk[idx]; pi_prev = pin[idx]; po_prev = pout[idx];
            if (abort_edge >= 0 && edges == abort_edge && pclk[idx] && !fin) begin
                start[idx] = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_outputs", {pen[idx], pclk[idx], busy[idx], done[idx], br[idx]}, 64'd0);
                fin = 1'b1;
            end
        end
        if (!fin) timeout = 1'b1;
        bv[idx] = 1'b0;
        start[idx] = 1'b0;
        post_edges = 0; post_dones = 0;
        pc_prev = pclk[idx];
        repeat (4) begin
            @(posedge clk); #1;
            if (pclk[idx] && !pc_prev) post_edges++;
            if (done[idx]) post_dones++;
            pc_prev = pclk[idx];
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            bv[i]    = 1'b0;
            bd[i]    = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_outputs_%0d", i),
                {busy[i], done[i], br[i], pen[i], pclk[i], pin[i], cerr[i]}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {busy[0], pen[0], pclk[0], br[0]}, 64'd0);

        // Two-byte load into a 16-bit chain
        run_load(0, 2, 8'hA5, 8'h3C, -1, 0, 1'b0, -1, -1);
        chk("t1_timeout", timeout, 1'b0);
        chk("t1_edges", edges, 16);
        chk("t1_bits", rec[15:0], 16'h3CA5);
        chk("t1_bytes", consumed, 2 + EXTRA);
        chk("t1_done", dones, 1);
        chk("t1_busy_at_done", busy_at_done, 1'b0);
        chk("t1_prog_in_stable", viol, 0);
        chk("t1_post_edges", post_edges, 0);
        chk("t1_post_done", post_dones, 0);
        chk("t1_idle_outs", {busy[0], pen[0], pclk[0], cerr[0]}, 64'd0);

        // Final byte partly used: only 2 of its bits reach the chain
        run_load(1, 2, 8'hFF, 8'h01, -1, 0, 1'b0, -1, -1);
        chk("t2_timeout", timeout, 1'b0);
        chk("t2_edges", edges, 10);
        chk("t2_bits", rec[9:0], 10'h1FF);
        chk("t2_bytes", consumed, 2 + EXTRA);
        chk("t2_done", dones, 1);
        chk("t2_prog_in_stable", viol, 0);
        chk("t2_post_edges", post_edges, 0);

        // Host withholds the second byte for 20 cycles
        run_load(0, 2, 8'hA5, 8'h3C, 1, 20, 1'b0, -1, -1);
        chk("t3_timeout", timeout, 1'b0);
        chk("t3_stall_cycles", stall_seen, 20);
        chk("t3_stall_outputs", stall_bad, 0);
        chk("t3_edges", edges, 16);
        chk("t3_bits", rec[15:0], 16'h3CA5);
        chk("t3_done", dones, 1);

        // Reset during the high phase of a chain bit aborts the load
        run_load(1, 2, 8'hFF, 8'h01, -1, 0, 1'b0, 6, -1);
        chk("t4_edges", edges, 6);
        chk("t4_done", dones + post_dones, 0);
        chk("t4_post_edges", post_edges, 0);
        chk("t4_busy", busy[1], 1'b0);

        // Restart after abort reloads the full stream
        run_load(1, 2, 8'h5A, 8'h03, -1, 0, 1'b0, -1, -1);
        chk("t5_timeout", timeout, 1'b0);
        chk("t5_edges", edges, 10);
        chk("t5_bits", rec[9:0], 10'h35A);
        chk("t5_bytes", consumed, 2 + EXTRA);
        chk("t5_done", dones, 1);

        // start pulsed mid-load is ignored
        run_load(0, 2, 8'h0F, 8'hF0, -1, 0, 1'b0, -1, 10);
        chk("t6_timeout", timeout, 1'b0);
        chk("t6_edges", edges, 16);
        chk("t6_bits", rec[15:0], 16'hF00F);
        chk("t6_done", dones, 1);
        chk("t6_post_done", post_dones, 0);
        chk("t6_post_edges", post_edges, 0);

`ifdef BITSTREAM_LOADER_CRC_EN
        // Zero-filled chain reads back eight zeros: CRC 0x00
        run_load(2, 1, 8'h5A, 8'h00, -1, 0, 1'b0, -1, -1);
        chk("t7_timeout", timeout, 1'b0);
        chk("t7_crc_model", crc_m, 8'h00);
        chk("t7_edges", edges, 8);
        chk("t7_bits", rec[7:0], 8'h5A);
        chk("t7_bytes", consumed, 2);
        chk("t7_done", dones, 1);
        chk("t7_crc_err", cerr[2], 1'b0);

        // Wrong expected CRC flags an error, still completes
        run_load(2, 1, 8'h5A, 8'h00, -1, 0, 1'b1, -1, -1);
        chk("t8_timeout", timeout, 1'b0);
        chk("t8_done", dones, 1);
        chk("t8_crc_err", cerr[2], 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
